// File: rtl/game_ctrl_fsm.sv
// Minesweeper game control: menu, board-init handshake, play/pause, win/fail hold, game over.
// Latency: all outputs registered; state follows a qualifying input pulse by one clock.
// Backpressure: none; pulses act in the cycle they arrive, NEW_GAME waits on board_ready.
module game_ctrl_fsm #(
   parameter int CLK_HZ   = 65_000_000,
   parameter int LEVELS   = 3,
   parameter int LVL_W    = 2,
   parameter int TIME_W   = 10,
   parameter int TIME_MAX = 999,
   parameter int CELLS_W  = 10,
   parameter int HOLD_SEC = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LVL_W-1:0]   level_sel,
   input  logic               pause_btn,
   input  logic               cell_revealed,
   input  logic               mine_hit,
   input  logic [CELLS_W-1:0] safe_cells,
   input  logic               board_ready,
   input  logic               ack,
   output logic [2:0]         state_o,
   output logic [LVL_W-1:0]   level_o,
   output logic               board_init,
   output logic [TIME_W-1:0]  timer_sec,
   output logic [CELLS_W-1:0] revealed_cnt,
   output logic               game_won,
   output logic               game_lost
);

   localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int HOLD_W  = $clog2(HOLD_SEC + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
   localparam logic [TIME_W-1:0]  TIME_LIM   = TIME_W'(TIME_MAX);
   localparam logic [HOLD_W-1:0]  HOLD_LIM   = HOLD_W'(HOLD_SEC);
   localparam logic [LVL_W:0]     LVL_LIM    = (LVL_W + 1)'(LEVELS);

   typedef enum logic [2:0] {
      S_MENU      = 3'd0,
      S_NEW_GAME  = 3'd1,
      S_PAUSE     = 3'd2,
      S_PLAY      = 3'd3,
      S_FAIL      = 3'd4,
      S_WIN       = 3'd5,
      S_GAME_OVER = 3'd6
   } state_t;

   state_t               state_q, state_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic                 binit_q, binit_d;
   logic [TIME_W-1:0]    timer_q, timer_d;
   logic [CELLS_W-1:0]   rev_q, rev_d;
   logic                 won_q, won_d;
   logic                 lost_q, lost_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;

   logic                 tick;
   logic                 start_ok;
   logic [CELLS_W:0]     rev_inc;
   logic                 win_hit;
   logic [TIME_W-1:0]    time_inc;
   logic                 new_game;
   logic                 enter_end;

   // A tick is the last cycle of a prescaler second; the compare is widened so a full count cannot wrap.
   assign tick     = (presc_q == PRESC_LAST);
   assign start_ok = start && ({1'b0, level_sel} < LVL_LIM);
   assign rev_inc  = {1'b0, rev_q} + 1'b1;
   assign win_hit  = cell_revealed && (rev_inc == {1'b0, safe_cells});
   assign time_inc = timer_q + 1'b1;

   // State register and all registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_MENU;
         level_q <= '0;
         binit_q <= 1'b0;
         timer_q <= '0;
         rev_q   <= '0;
         won_q   <= 1'b0;
         lost_q  <= 1'b0;
         presc_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         binit_q <= binit_d;
         timer_q <= timer_d;
         rev_q   <= rev_d;
         won_q   <= won_d;
         lost_q  <= lost_d;
         presc_q <= presc_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state and next-output logic; PLAY priority is mine, win, timeout, pause.
   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      binit_d   = 1'b0;
      timer_d   = timer_q;
      rev_d     = rev_q;
      won_d     = won_q;
      lost_d    = lost_q;
      presc_d   = presc_q;
      hold_d    = hold_q;
      new_game  = 1'b0;
      enter_end = 1'b0;

      case (state_q)
         S_MENU: begin
            if (start_ok) begin
               level_d  = level_sel;
               new_game = 1'b1;
            end
         end
         S_NEW_GAME: begin
            if (board_ready) state_d = S_PLAY;
         end
         S_PLAY: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick && (timer_q != TIME_LIM)) timer_d = time_inc;
            if (mine_hit) begin
               state_d   = S_FAIL;
               lost_d    = 1'b1;
               enter_end = 1'b1;
            end else begin
               if (cell_revealed && (rev_q < safe_cells)) rev_d = rev_inc[CELLS_W-1:0];
               if (win_hit) begin
                  state_d   = S_WIN;
                  won_d     = 1'b1;
                  enter_end = 1'b1;
               end else if (tick && (time_inc == TIME_LIM)) begin
                  state_d   = S_FAIL;
                  lost_d    = 1'b1;
                  enter_end = 1'b1;
               end else if (pause_btn) begin
                  state_d = S_PAUSE;
               end
            end
         end
         S_PAUSE: begin
            if (pause_btn) state_d = S_PLAY;
         end
         S_FAIL, S_WIN: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
               hold_d = hold_q + 1'b1;
               if ((hold_q + 1'b1) == HOLD_LIM) state_d = S_GAME_OVER;
            end
         end
         S_GAME_OVER: begin
            if (ack) begin
               state_d = S_MENU;
            end else if (start_ok) begin
               level_d  = level_sel;
               new_game = 1'b1;
            end
         end
         default: state_d = S_MENU;
      endcase

      // Entering NEW_GAME clears the per-game counters and flags alongside the board request.
      if (new_game) begin
         state_d = S_NEW_GAME;
         binit_d = 1'b1;
         timer_d = '0;
         rev_d   = '0;
         presc_d = '0;
         won_d   = 1'b0;
         lost_d  = 1'b0;
      end
      // The hold period always starts from a fresh second.
      if (enter_end) begin
         presc_d = '0;
         hold_d  = '0;
      end
   end

   assign state_o      = state_q;
   assign level_o      = level_q;
   assign board_init   = binit_q;
   assign timer_sec    = timer_q;
   assign revealed_cnt = rev_q;
   assign game_won     = won_q;
   assign game_lost    = lost_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Bench for game_ctrl_fsm: directed scenarios plus random traffic against a cycle-count model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: none; every wait on the design is bounded by a cycle budget.
module tb_game_ctrl_fsm;

   localparam int CLK_HZ   = 10;
   localparam int LEVELS   = 3;
   localparam int LVL_W    = 2;
   localparam int TIME_W   = 10;
   localparam int TIME_MAX = 5;
   localparam int CELLS_W  = 10;
   localparam int HOLD_SEC = 2;

   logic               clk;
   logic               rst;
   logic               start;
   logic [LVL_W-1:0]   level_sel;
   logic               pause_btn;
   logic               cell_revealed;
   logic               mine_hit;
   logic [CELLS_W-1:0] safe_cells;
   logic               board_ready;
   logic               ack;
   logic [2:0]         state_o;
   logic [LVL_W-1:0]   level_o;
   logic               board_init;
   logic [TIME_W-1:0]  timer_sec;
   logic [CELLS_W-1:0] revealed_cnt;
   logic               game_won;
   logic               game_lost;

   int errors = 0;
   int checks = 0;
   int binit_seen = 0;

   game_ctrl_fsm #(
      .CLK_HZ(CLK_HZ), .LEVELS(LEVELS), .LVL_W(LVL_W), .TIME_W(TIME_W),
      .TIME_MAX(TIME_MAX), .CELLS_W(CELLS_W), .HOLD_SEC(HOLD_SEC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .level_sel(level_sel), .pause_btn(pause_btn),
      .cell_revealed(cell_revealed), .mine_hit(mine_hit), .safe_cells(safe_cells),
      .board_ready(board_ready), .ack(ack), .state_o(state_o), .level_o(level_o),
      .board_init(board_init), .timer_sec(timer_sec), .revealed_cnt(revealed_cnt),
      .game_won(game_won), .game_lost(game_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts cycles with board_init high.
   always @(negedge clk) if (board_init === 1'b1) binit_seen <= binit_seen + 1;

   // Reference model: time is elapsed PLAY cycles divided by CLK_HZ, hold is elapsed cycles.
   int m_state = 0, m_level = 0, m_pc = 0, m_rev = 0, m_hc = 0;
   bit m_binit = 0, m_won = 0, m_lost = 0;

   function automatic int exp_timer(int pc);
      int t;
      t = pc / CLK_HZ;
      return (t > TIME_MAX) ? TIME_MAX : t;
   endfunction

   // Advances the model on every rising edge from the same inputs the design sees.
   always @(posedge clk) begin : model_blk
      int s, lv, pc, rv, hc;
      bit bi, wn, ls, fresh, win;
      s = m_state; lv = m_level; pc = m_pc; rv = m_rev; hc = m_hc;
      wn = m_won; ls = m_lost; bi = 0; fresh = 0;
      if (!rst) begin
         s = 0; lv = 0; pc = 0; rv = 0; hc = 0; wn = 0; ls = 0;
      end else begin
         case (s)
            0: if (start && level_sel < LEVELS) begin lv = int'(level_sel); fresh = 1; end
            1: if (board_ready) s = 3;
            2: if (pause_btn) s = 3;
            3: begin
               pc = pc + 1;
               win = cell_revealed && (rv + 1 == int'(safe_cells));
               if (mine_hit) begin
                  s = 4; ls = 1; hc = 0;
               end else begin
                  if (cell_revealed && rv < int'(safe_cells)) rv = rv + 1;
                  if (win) begin s = 5; wn = 1; hc = 0; end
                  else if (pc % CLK_HZ == 0 && pc / CLK_HZ == TIME_MAX) begin s = 4; ls = 1; hc = 0; end
                  else if (pause_btn) s = 2;
               end
            end
            4, 5: begin
               hc = hc + 1;
               if (hc == HOLD_SEC * CLK_HZ) s = 6;
            end
            6: begin
               if (ack) s = 0;
               else if (start && level_sel < LEVELS) begin lv = int'(level_sel); fresh = 1; end
            end
            default: s = 0;
         endcase
         if (fresh) begin s = 1; bi = 1; pc = 0; rv = 0; wn = 0; ls = 0; end
      end
      m_state <= s; m_level <= lv; m_pc <= pc; m_rev <= rv; m_hc <= hc;
      m_binit <= bi; m_won <= wn; m_lost <= ls;
   end

   task automatic clr_in();
      start = 0; pause_btn = 0; cell_revealed = 0; mine_hit = 0; board_ready = 0; ack = 0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, output int n);
      n = 0;
      while (state_o !== target && n < budget) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1; start = 1; level_sel = 2'd1; step(); clr_in();
      board_ready = 1; step(); clr_in();
      repeat (15) step();
      checks++;
      if (state_o !== 3'd3 || timer_sec !== 10'd1) begin
         errors++; $display("FAIL reset_pre_play: state=%0d timer=%0d, want state=3 timer=1", state_o, timer_sec);
      end
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (state_o !== 3'd0 || timer_sec !== 10'd0 || revealed_cnt !== 10'd0 || level_o !== 2'd0) begin
            errors++; $display("FAIL reset_regs cyc%0d: state=%0d timer=%0d rev=%0d lvl=%0d, want all 0", i, state_o, timer_sec, revealed_cnt, level_o);
         end
         checks++;
         if (game_won !== 1'b0 || game_lost !== 1'b0 || board_init !== 1'b0) begin
            errors++; $display("FAIL reset_flags cyc%0d: won=%b lost=%b binit=%b, want 0", i, game_won, game_lost, board_init);
         end
      end
      rst = 1;
   endtask

   task automatic test_win_path();
      int b0, n;
      b0 = binit_seen;
      start = 1; level_sel = 2'd2; step(); clr_in();
      checks++;
      if (state_o !== 3'd1 || board_init !== 1'b1 || level_o !== 2'd2) begin
         errors++; $display("FAIL win_newgame: state=%0d binit=%b lvl=%0d, want 1/1/2", state_o, board_init, level_o);
      end
      step();
      checks++;
      if (state_o !== 3'd1 || board_init !== 1'b0) begin
         errors++; $display("FAIL win_wait_ready: state=%0d binit=%b, want 1/0", state_o, board_init);
      end
      board_ready = 1; step(); clr_in();
      checks++;
      if (state_o !== 3'd3) begin errors++; $display("FAIL win_play: state=%0d, want 3", state_o); end
      for (int i = 1; i <= 3; i++) begin
         step();
         cell_revealed = 1; step(); clr_in();
         checks++;
         if (revealed_cnt !== 10'(i)) begin
            errors++; $display("FAIL win_reveal%0d: rev=%0d, want %0d", i, revealed_cnt, i);
         end
      end
      checks++;
      if (state_o !== 3'd5 || game_won !== 1'b1 || game_lost !== 1'b0) begin
         errors++; $display("FAIL win_state: state=%0d won=%b lost=%b, want 5/1/0", state_o, game_won, game_lost);
      end
      wait_state(3'd6, 40, n);
      checks++;
      if (state_o !== 3'd6 || n != HOLD_SEC * CLK_HZ) begin
         errors++; $display("FAIL win_hold: state=%0d after %0d cycles, want 6 after 20", state_o, n);
      end
      checks++;
      if (binit_seen - b0 != 1 || revealed_cnt !== 10'd3 || game_won !== 1'b1) begin
         errors++; $display("FAIL win_summary: binit_pulses=%0d rev=%0d won=%b, want 1/3/1", binit_seen - b0, revealed_cnt, game_won);
      end
   endtask

   task automatic test_timeout();
      int n;
      start = 1; level_sel = 2'd0; step(); clr_in();
      checks++;
      if (state_o !== 3'd1 || game_won !== 1'b0 || level_o !== 2'd0) begin
         errors++; $display("FAIL to_newgame: state=%0d won=%b lvl=%0d, want 1/0/0", state_o, game_won, level_o);
      end
      board_ready = 1; step(); clr_in();
      for (int k = 1; k <= 50; k++) begin
         step();
         checks++;
         if (timer_sec !== 10'(k / CLK_HZ)) begin
            errors++; $display("FAIL to_timer k=%0d: timer=%0d, want %0d", k, timer_sec, k / CLK_HZ);
         end
         checks++;
         if ((k < 50 && state_o !== 3'd3) || (k == 50 && (state_o !== 3'd4 || game_lost !== 1'b1))) begin
            errors++; $display("FAIL to_state k=%0d: state=%0d lost=%b, want %0d", k, state_o, game_lost, (k < 50) ? 3 : 4);
         end
      end
      wait_state(3'd6, 30, n);
      checks++;
      if (state_o !== 3'd6 || timer_sec !== 10'd5) begin
         errors++; $display("FAIL to_over: state=%0d timer=%0d, want 6/5", state_o, timer_sec);
      end
   endtask

   task automatic test_pause();
      start = 1; level_sel = 2'd1; step(); clr_in();
      board_ready = 1; step(); clr_in();
      repeat (4) step();
      pause_btn = 1; step(); clr_in();
      checks++;
      if (state_o !== 3'd2) begin errors++; $display("FAIL pause_enter: state=%0d, want 2", state_o); end
      for (int i = 1; i <= 50; i++) begin
         if (i == 20) mine_hit = 1;
         if (i == 30) cell_revealed = 1;
         step(); clr_in();
         checks++;
         if (state_o !== 3'd2 || timer_sec !== 10'd0 || revealed_cnt !== 10'd0) begin
            errors++; $display("FAIL pause_hold i=%0d: state=%0d timer=%0d rev=%0d, want 2/0/0", i, state_o, timer_sec, revealed_cnt);
         end
      end
      pause_btn = 1; step(); clr_in();
      checks++;
      if (state_o !== 3'd3) begin errors++; $display("FAIL pause_resume: state=%0d, want 3", state_o); end
      for (int j = 1; j <= 5; j++) begin
         step();
         checks++;
         if (timer_sec !== ((j < 5) ? 10'd0 : 10'd1)) begin
            errors++; $display("FAIL pause_tick j=%0d: timer=%0d, want %0d", j, timer_sec, (j < 5) ? 0 : 1);
         end
      end
   endtask

   task automatic test_priority();
      int n;
      cell_revealed = 1; step(); clr_in();
      cell_revealed = 1; step(); clr_in();
      checks++;
      if (revealed_cnt !== 10'd2 || state_o !== 3'd3) begin
         errors++; $display("FAIL prio_setup: rev=%0d state=%0d, want 2/3", revealed_cnt, state_o);
      end
      mine_hit = 1; cell_revealed = 1; step(); clr_in();
      checks++;
      if (state_o !== 3'd4 || revealed_cnt !== 10'd2 || game_won !== 1'b0 || game_lost !== 1'b1) begin
         errors++; $display("FAIL prio_mine: state=%0d rev=%0d won=%b lost=%b, want 4/2/0/1", state_o, revealed_cnt, game_won, game_lost);
      end
      wait_state(3'd6, 30, n);
      checks++;
      if (state_o !== 3'd6) begin errors++; $display("FAIL prio_over: state=%0d, want 6", state_o); end
   endtask

   task automatic test_menu_guards();
      int n;
      ack = 1; start = 1; level_sel = 2'd2; step(); clr_in();
      checks++;
      if (state_o !== 3'd0 || level_o !== 2'd1 || game_lost !== 1'b1) begin
         errors++; $display("FAIL guard_ack_wins: state=%0d lvl=%0d lost=%b, want 0/1/1", state_o, level_o, game_lost);
      end
      start = 1; level_sel = 2'd3; step(); clr_in();
      step();
      checks++;
      if (state_o !== 3'd0 || level_o !== 2'd1 || board_init !== 1'b0) begin
         errors++; $display("FAIL guard_bad_level: state=%0d lvl=%0d binit=%b, want 0/1/0", state_o, level_o, board_init);
      end
      start = 1; level_sel = 2'd0; step(); clr_in();
      board_ready = 1; step(); clr_in();
      mine_hit = 1; step(); clr_in();
      wait_state(3'd6, 30, n);
      start = 1; level_sel = 2'd3; step(); clr_in();
      checks++;
      if (state_o !== 3'd6) begin errors++; $display("FAIL guard_over_bad: state=%0d, want 6", state_o); end
      start = 1; level_sel = 2'd2; step(); clr_in();
      checks++;
      if (state_o !== 3'd1 || level_o !== 2'd2 || game_lost !== 1'b0 || game_won !== 1'b0 || board_init !== 1'b1) begin
         errors++; $display("FAIL guard_restart: state=%0d lvl=%0d won=%b lost=%b binit=%b, want 1/2/0/0/1",
                            state_o, level_o, game_won, game_lost, board_init);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         rst           = ($urandom_range(0, 299) != 0);
         start         = ($urandom_range(0, 7) == 0);
         level_sel     = 2'($urandom_range(0, 3));
         pause_btn     = ($urandom_range(0, 9) == 0);
         cell_revealed = ($urandom_range(0, 3) == 0);
         mine_hit      = ($urandom_range(0, 59) == 0);
         board_ready   = ($urandom_range(0, 2) == 0);
         ack           = ($urandom_range(0, 14) == 0);
         if (m_state == 0 || m_state == 6) safe_cells = 10'($urandom_range(1, 5));
         step();
         checks++;
         if (state_o !== 3'(m_state) || level_o !== 2'(m_level) || board_init !== m_binit) begin
            errors++; $display("FAIL rnd_ctrl c=%0d: state=%0d lvl=%0d binit=%b, want %0d/%0d/%b",
                               c, state_o, level_o, board_init, m_state, m_level, m_binit);
         end
         checks++;
         if (timer_sec !== 10'(exp_timer(m_pc)) || revealed_cnt !== 10'(m_rev)) begin
            errors++; $display("FAIL rnd_count c=%0d: timer=%0d rev=%0d, want %0d/%0d",
                               c, timer_sec, revealed_cnt, exp_timer(m_pc), m_rev);
         end
         checks++;
         if (game_won !== m_won || game_lost !== m_lost || (game_won && game_lost)) begin
            errors++; $display("FAIL rnd_flags c=%0d: won=%b lost=%b, want %b/%b", c, game_won, game_lost, m_won, m_lost);
         end
      end
      rst = 1; clr_in();
   endtask

   initial begin
      rst = 0; level_sel = '0; safe_cells = 10'd3;
      clr_in();
      repeat (2) step();
      test_reset();
      test_win_path();
      test_timeout();
      test_pause();
      test_priority();
      test_menu_guards();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
